// File: rtl/n4_b2_sar_searcher.sv
// Binary (successive-approximation) search for a secret signed 4-bit value
// held behind an external combinational comparator.
//
// Ports:
//   clock, reset_       : rising-edge clock, asynchronous active-low reset
//   start               : request a new search (honoured in IDLE/DONE/ERR only)
//   g3_g0               : registered signed probe presented to the comparator
//   flag_eq/gr/lr       : comparator result for x == g, x > g, x < g
//   r3_r0               : signed result of the last successful search
//   p2_p0               : probes used by the last or current search
//   busy, done, err     : registered status levels
module n4_b2_sar_searcher (
  input  logic       clock,
  input  logic       reset_,
  input  logic       start,
  input  logic       flag_eq,
  input  logic       flag_gr,
  input  logic       flag_lr,
  output logic [3:0] g3_g0,
  output logic [3:0] r3_r0,
  output logic [2:0] p2_p0,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned VAL_W = 4;
  localparam int unsigned BND_W = 5;
  localparam int unsigned SUM_W = 6;
  localparam int unsigned CNT_W = 3;

  localparam logic [CNT_W-1:0]        MAX_PROBES = CNT_W'(5);
  localparam logic signed [BND_W-1:0] LO_INIT    = -5'sd8;
  localparam logic signed [BND_W-1:0] HI_INIT    = 5'sd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SET,
    ST_CMP,
    ST_DONE,
    ST_ERR
  } state_t;

  state_t state, state_nxt;

  logic signed [BND_W-1:0] lo, hi, lo_nxt, hi_nxt;
  logic signed [BND_W-1:0] mid, mid_inc, mid_dec;
  logic signed [SUM_W-1:0] sum;
  logic [VAL_W-1:0]        g_nxt, r_nxt;
  logic [CNT_W-1:0]        p_nxt;
  logic                    busy_nxt, done_nxt, err_nxt;
  logic                    eq_only, gr_only, lr_only, cmp_fail;

  // Midpoint: sign-extend both bounds so the 6-bit sum cannot overflow.
  assign sum     = {lo[BND_W-1], lo} + {hi[BND_W-1], hi};
  assign mid     = BND_W'(sum >>> 1);
  assign mid_inc = mid + 5'sd1;
  assign mid_dec = mid - 5'sd1;

  // Comparator decode; anything other than exactly one flag is a fault.
  assign eq_only = {flag_eq, flag_gr, flag_lr} == 3'b100;
  assign gr_only = {flag_eq, flag_gr, flag_lr} == 3'b010;
  assign lr_only = {flag_eq, flag_gr, flag_lr} == 3'b001;

  // Search fails on a bad flag pattern, an empty interval, or running out of probes.
  assign cmp_fail = !(eq_only || gr_only || lr_only)
                 || (gr_only && (mid_inc > hi))
                 || (lr_only && (lo > mid_dec))
                 || ((p2_p0 == MAX_PROBES) && !eq_only);

  // State register.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR: if (start) state_nxt = ST_SET;
      ST_SET:                   state_nxt = ST_CMP;
      ST_CMP: begin
        if (cmp_fail)     state_nxt = ST_ERR;
        else if (eq_only) state_nxt = ST_DONE;
        else              state_nxt = ST_SET;
      end
      default:                  state_nxt = ST_IDLE;
    endcase
  end

  // Output / datapath next values; everything holds unless a transition updates it.
  always_comb begin
    lo_nxt   = lo;
    hi_nxt   = hi;
    g_nxt    = g3_g0;
    r_nxt    = r3_r0;
    p_nxt    = p2_p0;
    busy_nxt = busy;
    done_nxt = done;
    err_nxt  = err;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          lo_nxt   = LO_INIT;
          hi_nxt   = HI_INIT;
          p_nxt    = '0;
          busy_nxt = 1'b1;
          done_nxt = 1'b0;
          err_nxt  = 1'b0;
        end
      end
      ST_SET: begin
        g_nxt = mid[VAL_W-1:0];
        p_nxt = p2_p0 + CNT_W'(1);
      end
      ST_CMP: begin
        if (cmp_fail) begin
          busy_nxt = 1'b0;
          err_nxt  = 1'b1;
        end else if (eq_only) begin
          r_nxt    = g3_g0;
          busy_nxt = 1'b0;
          done_nxt = 1'b1;
        end else if (gr_only) begin
          lo_nxt = mid_inc;
        end else begin
          hi_nxt = mid_dec;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      lo    <= LO_INIT;
      hi    <= HI_INIT;
      g3_g0 <= '0;
      r3_r0 <= '0;
      p2_p0 <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      lo    <= lo_nxt;
      hi    <= hi_nxt;
      g3_g0 <= g_nxt;
      r3_r0 <= r_nxt;
      p2_p0 <= p_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
      err   <= err_nxt;
    end
  end

endmodule

// File: tb/tb_n4_b2_sar_searcher.sv
// Self-checking bench for n4_b2_sar_searcher: a comparator stub hides a secret
// value; expected probe sequences come from a floor-midpoint interval model.
module tb_n4_b2_sar_searcher;

  logic       clock = 1'b0;
  logic       reset_;
  logic       start;
  logic       flag_eq, flag_gr, flag_lr;
  logic [3:0] g3_g0, r3_r0;
  logic [2:0] p2_p0;
  logic       busy, done, err;

  int secret;
  bit bad;
  int n_vec = 0;
  int n_err = 0;
  int exp_probes[$];
  int got_probes[$];

  logic signed [3:0] g_s, r_s;
  assign g_s = g3_g0;
  assign r_s = r3_r0;

  n4_b2_sar_searcher dut (
    .clock   (clock),
    .reset_  (reset_),
    .start   (start),
    .flag_eq (flag_eq),
    .flag_gr (flag_gr),
    .flag_lr (flag_lr),
    .g3_g0   (g3_g0),
    .r3_r0   (r3_r0),
    .p2_p0   (p2_p0),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clock = ~clock;

  // Comparator stub; 'bad' forces an illegal two-hot answer.
  always_comb begin
    if (bad) begin
      flag_eq = 1'b0;
      flag_gr = 1'b1;
      flag_lr = 1'b1;
    end else begin
      flag_eq = (secret == int'(g_s));
      flag_gr = (secret >  int'(g_s));
      flag_lr = (secret <  int'(g_s));
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: shrink the interval [-8,7] around x using the floor midpoint.
  task automatic build_model(input int x);
    int lo, hi, m;
    lo = -8;
    hi = 7;
    exp_probes.delete();
    while (exp_probes.size() < 5) begin
      m = int'($floor(real'(lo + hi) / 2.0));
      exp_probes.push_back(m);
      if (m == x) break;
      if (x > m) lo = m + 1;
      else       hi = m - 1;
    end
  endtask

  // One start pulse, then watch until done/err (bounded); optional start noise while busy.
  task automatic do_search(input int x, input bit noise);
    int fin, busy_gaps, n;
    secret = x;
    bad    = 1'b0;
    build_model(x);
    n = exp_probes.size();
    got_probes.delete();
    fin       = 0;
    busy_gaps = 0;
    @(negedge clock) start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    if (!busy) busy_gaps++;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      @(posedge clock); #1;
      if (done || err) begin
        fin = cyc;
        break;
      end
      if (!busy) busy_gaps++;
      if ((cyc % 2) == 1) got_probes.push_back(int'(g_s));
      if (noise) start = 1'($urandom_range(0, 1));
    end
    start = 1'b0;
    check($sformatf("x=%0d finish_cycle", x), fin, 2 * n);
    check($sformatf("x=%0d busy_level", x), busy_gaps, 0);
    check($sformatf("x=%0d done", x), int'(done), 1);
    check($sformatf("x=%0d err", x), int'(err), 0);
    check($sformatf("x=%0d busy_after", x), int'(busy), 0);
    check($sformatf("x=%0d result", x), int'(r_s), x);
    check($sformatf("x=%0d probes_used", x), int'(p2_p0), n);
    check($sformatf("x=%0d probe_count", x), got_probes.size(), n);
    for (int i = 0; i < n && i < got_probes.size(); i++)
      check($sformatf("x=%0d probe%0d", x, i), got_probes[i], exp_probes[i]);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " g"},    int'(g3_g0), 0);
    check({tag, " r"},    int'(r3_r0), 0);
    check({tag, " p"},    int'(p2_p0), 0);
    check({tag, " busy"}, int'(busy),  0);
    check({tag, " done"}, int'(done),  0);
    check({tag, " err"},  int'(err),   0);
  endtask

  initial begin
    int fin;
    reset_ = 1'b0;
    start  = 1'b0;
    secret = 0;
    bad    = 1'b0;
    #12;
    check_reset_values("por");
    @(negedge clock) reset_ = 1'b1;

    // Directed cases from the interval corners and an interior value.
    do_search(5, 1'b0);
    do_search(-8, 1'b0);
    do_search(7, 1'b0);

    // Illegal comparator answer on the first probe.
    bad    = 1'b1;
    secret = 0;
    @(negedge clock) start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    check("bad busy_e0", int'(busy), 1);
    @(posedge clock); #1;
    check("bad err_e1", int'(err), 0);
    @(posedge clock); #1;
    check("bad err_e2", int'(err), 1);
    check("bad done_e2", int'(done), 0);
    check("bad busy_e2", int'(busy), 0);
    check("bad result_kept", int'(r_s), 7);
    check("bad probes_used", int'(p2_p0), 1);
    @(posedge clock); #1;
    check("bad err_hold", int'(err), 1);
    bad = 1'b0;

    // Asynchronous reset during the second probe, then a fresh search.
    secret = 0;
    @(negedge clock) start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst second_probe", int'(g_s), 3);
    #2 reset_ = 1'b0;
    #1;
    check_reset_values("midrst");
    @(negedge clock);
    @(negedge clock) reset_ = 1'b1;
    do_search(0, 1'b0);

    // start held high: restart from DONE without an idle cycle.
    secret = 5;
    @(negedge clock) start = 1'b1;
    repeat (7) @(posedge clock);
    #1;
    check("b2b done_e6", int'(done), 1);
    check("b2b result_e6", int'(r_s), 5);
    @(posedge clock); #1;
    check("b2b busy_e7", int'(busy), 1);
    check("b2b done_e7", int'(done), 0);
    check("b2b p_e7", int'(p2_p0), 0);
    start = 1'b0;
    fin = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(posedge clock); #1;
      if (done || err) begin
        fin = 1;
        break;
      end
    end
    check("b2b second_finished", fin, 1);
    check("b2b second_result", int'(r_s), 5);

    // Full sweep and random values, with start noise while busy.
    for (int x = -8; x <= 7; x++) do_search(x, 1'b1);
    repeat (12) do_search(int'($urandom_range(0, 15)) - 8, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
